// File: rtl/q2_write_sequencer.sv
// Two-source round-robin feeder that drains buffered words as write pulses.
// Latency: word accepted at edge t -> wr_en during t+1..t+2, rd_en t+2..t+3.
// Backpressure: both readies drop while the FIFO is full, even if it pops.

// Generic synchronous FIFO with occupancy count; head is read combinationally.
// Latency: a pushed word is visible at pop_dat one edge after the push.
// Backpressure: caller must not push when full nor pop when empty.
module q2_sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
endmodule

// Round-robin arbiter, word FIFO and IDLE/WRITE/READ drain sequencer.
// Latency: 1 cycle from accept to wr_en; drain 1 word/cycle or 1 per 2 cycles.
// Backpressure: src readies follow FIFO full and the round-robin grant only.
module q2_write_sequencer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int READBACK = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        src1_data,
    input  logic                     src1_valid,
    output logic                     src1_ready,
    input  logic [DATA_W-1:0]        src2_data,
    input  logic                     src2_valid,
    output logic                     src2_ready,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     wr_src,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              full;
    logic              empty;
    logic              push1;
    logic              push2;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   push_dat;
    logic [DATA_W:0]   head_dat;

    // last_grant holds the id of the last contested winner (0 = src1).
    assign src1_ready = !full && (!src2_valid || last_grant);
    assign src2_ready = !full && (!src1_valid || !last_grant);

    // The ready terms are mutually exclusive under contention, so at most one push.
    assign push1    = src1_valid && src1_ready;
    assign push2    = src2_valid && src2_ready;
    assign push     = push1 || push2;
    assign push_dat = push1 ? {1'b0, src1_data} : {1'b1, src2_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (src1_valid && src2_valid && push) begin
            last_grant <= push2;
        end
    end

    q2_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fifo_count),
        .full     (full),
        .empty    (empty)
    );

    // Every entry into WRITE pops the head, so the pop coincides with the
    // edge that registers wr_data/wr_src.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (READBACK != 0) begin
                    state_nxt = READ;
                end else if (!empty) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (!empty) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pop = (state_nxt == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            wr_data <= '0;
            wr_src  <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= (state_nxt == WRITE);
            rd_en <= (state_nxt == READ);
            if (pop) begin
                {wr_src, wr_data} <= head_dat;
            end
        end
    end
endmodule

// File: tb/tb_q2_write_sequencer.sv
// Drives a READBACK=1 instance (index 0) and a READBACK=0 instance (index 1)
// from queued sources and compares both against a queue-and-timing model.
`timescale 1ns/1ps
module tb_q2_write_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s1d [2];
    logic [15:0] s2d [2];
    logic [15:0] wd  [2];
    logic        s1v [2];
    logic        s2v [2];
    logic        s1r [2];
    logic        s2r [2];
    logic        wen [2];
    logic        ren [2];
    logic        wsrc[2];
    logic [2:0]  fc  [2];

    always #5 clk = ~clk;

    q2_write_sequencer #(.DATA_W(16), .DEPTH(DEPTH), .READBACK(1)) u_rb1 (
        .clk(clk), .rst_n(rst_n),
        .src1_data(s1d[0]), .src1_valid(s1v[0]), .src1_ready(s1r[0]),
        .src2_data(s2d[0]), .src2_valid(s2v[0]), .src2_ready(s2r[0]),
        .wr_data(wd[0]), .wr_src(wsrc[0]), .wr_en(wen[0]), .rd_en(ren[0]),
        .fifo_count(fc[0])
    );

    q2_write_sequencer #(.DATA_W(16), .DEPTH(DEPTH), .READBACK(0)) u_rb0 (
        .clk(clk), .rst_n(rst_n),
        .src1_data(s1d[1]), .src1_valid(s1v[1]), .src1_ready(s1r[1]),
        .src2_data(s2d[1]), .src2_valid(s2v[1]), .src2_ready(s2r[1]),
        .wr_data(wd[1]), .wr_src(wsrc[1]), .wr_en(wen[1]), .rd_en(ren[1]),
        .fifo_count(fc[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered list of {src,data}, a write slot rule
    // (write whenever buffered and at least 2 or 1 cycles since the last one).
    logic [16:0] mq [2][8];
    int          mn [2];
    int          earliest [2];
    int          lastwr [2];
    logic        lg [2];
    logic        ewen [2], eren [2], ewsrc [2];
    logic [15:0] ewd [2];
    logic        er1 [2], er2 [2], dr1 [2], dr2 [2];
    int          cyc = 0;

    // Source word lists, per instance and source.
    logic [15:0] sw [2][2][64];
    int          sh [2][2];
    int          sl [2][2];
    int          gap_pct = 0;
    bit          force_v = 1'b0;

    // Statistics for the directed scenarios.
    int          nwr [2], nrd [2];
    int          run1, maxrun1, maxc0;
    bit          rdy_drop0;
    logic        hist [$];

    task automatic model_reset(input int i);
        mn[i] = 0; lg[i] = 1'b1; earliest[i] = 0; lastwr[i] = -100;
        ewen[i] = 1'b0; eren[i] = 1'b0; ewd[i] = '0; ewsrc[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int gap = (i == 0) ? 2 : 1;
        eren[i] = (i == 0) && (lastwr[i] == cyc - 1);
        ewen[i] = 1'b0;
        if (mn[i] > 0 && cyc >= earliest[i]) begin
            ewen[i] = 1'b1;
            {ewsrc[i], ewd[i]} = mq[i][0];
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
            earliest[i] = cyc + gap;
            lastwr[i] = cyc;
        end
        if (s1v[i] && er1[i]) begin
            mq[i][mn[i]] = {1'b0, s1d[i]}; mn[i]++;
            if (s2v[i]) lg[i] = 1'b0;
        end else if (s2v[i] && er2[i]) begin
            mq[i][mn[i]] = {1'b1, s2d[i]}; mn[i]++;
            if (s1v[i]) lg[i] = 1'b1;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin nwr[i] = 0; nrd[i] = 0; end
        run1 = 0; maxrun1 = 0; maxc0 = 0; rdy_drop0 = 1'b0;
        hist.delete();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 2; s++) begin sh[i][s] = 0; sl[i][s] = 0; end
    endtask

    task automatic load(input int i, input int s, input logic [15:0] w);
        sw[i][s][sl[i][s] % 64] = w;
        sl[i][s]++;
    endtask

    function automatic bit is_idle();
        bit r = (mn[0] == 0) && (mn[1] == 0);
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 2; s++)
                if (sh[i][s] != sl[i][s]) r = 1'b0;
        return r;
    endfunction

    // One clock: drive at negedge, check readies, update model, check outputs.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            bit en1, en2;
            en1 = ($urandom_range(99) >= gap_pct);
            en2 = ($urandom_range(99) >= gap_pct);
            s1v[i] = force_v || (rst_n && (sh[i][0] != sl[i][0]) && en1);
            s2v[i] = force_v || (rst_n && (sh[i][1] != sl[i][1]) && en2);
            s1d[i] = (sh[i][0] != sl[i][0]) ? sw[i][0][sh[i][0] % 64] : 16'($urandom);
            s2d[i] = (sh[i][1] != sl[i][1]) ? sw[i][1][sh[i][1] % 64] : 16'($urandom);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            bit full;
            full = (mn[i] == DEPTH);
            er1[i] = !full && (!s2v[i] || lg[i]);
            er2[i] = !full && (!s1v[i] || !lg[i]);
            if (rst_n) begin
                check($sformatf("src1_ready_i%0d", i), s1r[i], er1[i]);
                check($sformatf("src2_ready_i%0d", i), s2r[i], er2[i]);
            end
            dr1[i] = s1r[i];
            dr2[i] = s2r[i];
        end
        if (s1v[0] && !s1r[0] && rst_n) rdy_drop0 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else begin
                model_edge(i);
                if (s1v[i] && dr1[i] && sh[i][0] != sl[i][0]) sh[i][0]++;
                if (s2v[i] && dr2[i] && sh[i][1] != sl[i][1]) sh[i][1]++;
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wr_en_i%0d", i), wen[i], ewen[i]);
            check($sformatf("rd_en_i%0d", i), ren[i], eren[i]);
            check($sformatf("wr_data_i%0d", i), wd[i], ewd[i]);
            check($sformatf("wr_src_i%0d", i), wsrc[i], ewsrc[i]);
            check($sformatf("fifo_count_i%0d", i), fc[i], mn[i]);
            nwr[i] += int'(wen[i]);
            nrd[i] += int'(ren[i]);
        end
        if (int'(fc[0]) > maxc0) maxc0 = int'(fc[0]);
        if (wen[0]) hist.push_back(wsrc[0]);
        run1 = wen[1] ? run1 + 1 : 0;
        if (run1 > maxrun1) maxrun1 = run1;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (n < bound && !is_idle()) begin step(); n++; end
        check({tag, "_drain_timeout"}, 32'(n < bound), 1);
        repeat (4) step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            s1v[i] = 1'b0; s2v[i] = 1'b0; s1d[i] = '0; s2d[i] = '0;
        end
        clear_sources();
        clear_stats();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset with both valids high.
        force_v = 1'b1;
        repeat (2) step();
        check("rst_wr_en", wen[0], 0);
        check("rst_rd_en", ren[0], 0);
        check("rst_wr_data", wd[0], 0);
        check("rst_wr_src", wsrc[0], 0);
        check("rst_fifo_count", fc[0], 0);
        rst_n = 1'b1;
        s1v[0] = 1'b1; s2v[0] = 1'b1;
        #1;
        check("rst_src1_ready", s1r[0], 1);
        check("rst_src2_ready", s2r[0], 0);
        step();
        force_v = 1'b0;
        drain("reset", 20);

        // Single word.
        clear_stats();
        load(0, 0, 16'hA5A5);
        load(1, 0, 16'hA5A5);
        drain("single", 20);
        check("single_nwr_rb1", nwr[0], 1);
        check("single_nrd_rb1", nrd[0], 1);
        check("single_nwr_rb0", nwr[1], 1);
        check("single_nrd_rb0", nrd[1], 0);
        check("single_hold", wd[0], 16'hA5A5);

        // Contention from a fresh reset.
        do_reset(1);
        clear_stats();
        for (int k = 0; k < 6; k++) begin
            load(0, 0, 16'h1111); load(0, 1, 16'h2222);
            load(1, 0, 16'h1111); load(1, 1, 16'h2222);
        end
        drain("contention", 100);
        for (int k = 0; k < 4; k++)
            check($sformatf("cont_src%0d", k), (hist.size() > k) ? hist[k] : 1'bx, k % 2);
        check("cont_nwr", nwr[0], 12);

        // Fill to full with back-to-back src1 words.
        clear_stats();
        for (int k = 1; k <= 8; k++) begin
            load(0, 0, 16'(k)); load(1, 0, 16'(k));
        end
        drain("full", 60);
        check("full_max_cnt", maxc0, 4);
        check("full_ready_drop", 32'(rdy_drop0), 1);
        check("full_nwr", nwr[0], 8);

        // Reset mid-drain with three entries buffered.
        begin
            int n = 0;
            for (int k = 1; k <= 8; k++) load(0, 0, 16'(16'h0100 + k));
            while (n < 40 && !(fc[0] == 3'd3 && wen[0])) begin step(); n++; end
            check("mid_rst_reached", 32'(n < 40), 1);
            clear_sources();
            rst_n = 1'b0;
            step();
            check("mid_rst_wr_en", wen[0], 0);
            check("mid_rst_cnt", fc[0], 0);
            rst_n = 1'b1;
            clear_stats();
            repeat (10) step();
            check("mid_rst_no_wr", nwr[0], 0);
        end

        // READBACK=0 back-to-back drain.
        clear_stats();
        for (int k = 0; k < 4; k++) load(1, 1, 16'($urandom));
        drain("rb0", 30);
        check("rb0_run", maxrun1, 4);
        check("rb0_nrd", nrd[1], 0);
        check("rb0_nwr", nwr[1], 4);

        // Randomized traffic with occasional resets.
        gap_pct = 30;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) < 60) begin
                int i, s;
                i = $urandom_range(1);
                s = $urandom_range(1);
                if (sl[i][s] - sh[i][s] < 20) load(i, s, 16'($urandom));
            end
            rst_n = ($urandom_range(249) != 0);
            step();
        end
        rst_n = 1'b1;
        gap_pct = 0;
        drain("random", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
